// File: rtl/word_pair_split_pkg.sv
// Shared constants and types for the line split / word compress datapath.
// Lines are LINE_W bits wide and leave the splitter as pairs of WORD_W-bit words.
package word_pair_split_pkg;

  localparam int WORD_W         = 32;
  localparam int LINE_W         = 128;
  localparam int BEATS_PER_LINE = LINE_W / (2 * WORD_W);

  // w1 sits in the low half so a pair maps directly onto a line slice.
  typedef struct packed {
    logic [WORD_W-1:0] w2;
    logic [WORD_W-1:0] w1;
  } word_pair_t;

endpackage

// File: rtl/word_pair_split_if.sv
// Line-in / word-pair-out handshake bundle for word_pair_split.
// The slave modport is the splitter; the master modport is its environment.
interface word_pair_split_if;
  import word_pair_split_pkg::*;

  logic [LINE_W-1:0] i_line;
  logic              i_valid;
  logic              o_ready;
  logic [WORD_W-1:0] o_word1;
  logic [WORD_W-1:0] o_word2;
  logic              o_valid;
  logic              i_ready;
  logic              o_last;

  modport slave (
    input  i_line, i_valid, i_ready,
    output o_ready, o_word1, o_word2, o_valid, o_last
  );

  modport master (
    output i_line, i_valid, i_ready,
    input  o_ready, o_word1, o_word2, o_valid, o_last
  );

endinterface

// File: rtl/word_pair_split.sv
// Splits 128-bit lines into beats of two 32-bit words, lowest word first, with an
// active and a pending slot so lines stream back to back. WORD_SPLIT_STATS_EN adds o_line_cnt.
module word_pair_split
  import word_pair_split_pkg::*;
#(
  parameter int WIDTH   = WORD_W,
  parameter int I_WIDTH = LINE_W
) (
  input  logic              i_clk,
  input  logic              i_reset,
  word_pair_split_if.slave  bus
`ifdef WORD_SPLIT_STATS_EN
  ,
  output logic [15:0]       o_line_cnt
`endif
);

  localparam int BEATS  = I_WIDTH / (2 * WIDTH);
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);

  logic [I_WIDTH-1:0] act_line_q,  act_line_d;
  logic               act_valid_q, act_valid_d;
  logic [I_WIDTH-1:0] pend_line_q,  pend_line_d;
  logic               pend_valid_q, pend_valid_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;

  logic [2*WIDTH-1:0] pair_w [BEATS];
  logic               last_w;
  logic               xfer_w;
  logic               accept_w;

  assign bus.o_ready = !pend_valid_q && !i_reset;
  assign last_w      = act_valid_q && (beat_q == BEAT_LAST);
  assign xfer_w      = act_valid_q && bus.i_ready;
  assign accept_w    = bus.i_valid && bus.o_ready;

  always_comb begin
    for (int b = 0; b < BEATS; b++) begin
      pair_w[b] = act_line_q[b*2*WIDTH +: 2*WIDTH];
    end
  end

  assign bus.o_valid = act_valid_q;
  assign bus.o_last  = last_w;
  assign bus.o_word1 = pair_w[beat_q][WIDTH-1:0];
  assign bus.o_word2 = pair_w[beat_q][2*WIDTH-1:WIDTH];

  always_comb begin
    act_line_d   = act_line_q;
    act_valid_d  = act_valid_q;
    pend_line_d  = pend_line_q;
    pend_valid_d = pend_valid_q;
    beat_d       = beat_q;

    if (xfer_w) begin
      if (last_w) begin
        beat_d = '0;
        if (pend_valid_q) begin
          act_line_d   = pend_line_q;
          pend_valid_d = 1'b0;
        end else begin
          act_valid_d = 1'b0;
        end
      end else begin
        beat_d = beat_q + BEAT_W'(1);
      end
    end

    // accept_w implies the pending slot is empty, so a freeing active slot takes the line.
    if (accept_w) begin
      if (!act_valid_q || (xfer_w && last_w)) begin
        act_line_d  = bus.i_line;
        act_valid_d = 1'b1;
      end else begin
        pend_line_d  = bus.i_line;
        pend_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      act_line_q   <= '0;
      act_valid_q  <= 1'b0;
      pend_line_q  <= '0;
      pend_valid_q <= 1'b0;
      beat_q       <= '0;
    end else begin
      act_line_q   <= act_line_d;
      act_valid_q  <= act_valid_d;
      pend_line_q  <= pend_line_d;
      pend_valid_q <= pend_valid_d;
      beat_q       <= beat_d;
    end
  end

`ifdef WORD_SPLIT_STATS_EN
  logic [15:0] line_cnt_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      line_cnt_q <= '0;
    end else if (xfer_w && last_w) begin
      line_cnt_q <= line_cnt_q + 16'd1;
    end
  end

  assign o_line_cnt = line_cnt_q;
`endif

endmodule

// File: tb/tb_word_pair_split.sv
// Self-checking bench for word_pair_split: directed scenarios plus random traffic,
// compared cycle by cycle against a queue-of-lines reference model.
module tb_word_pair_split;
  import word_pair_split_pkg::*;

  logic i_clk = 1'b0;
  logic i_reset;
  always #5 i_clk = ~i_clk;

  word_pair_split_if bus ();

`ifdef WORD_SPLIT_STATS_EN
  logic [15:0] line_cnt;
`endif

  word_pair_split dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .bus        (bus)
`ifdef WORD_SPLIT_STATS_EN
    ,
    .o_line_cnt (line_cnt)
`endif
  );

  logic [LINE_W-1:0] mq[$];
  int beat;
  int lines_done;
  int n_tests;
  int n_fail;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive at the falling edge, check just after, advance the model at the rising edge.
  task automatic cyc(input logic [LINE_W-1:0] line, input logic v, input logic r);
    logic [LINE_W-1:0] head;
    word_pair_t        p;
    logic              exp_ready;
    logic              exp_valid;
    logic              exp_last;
    bus.i_line  = line;
    bus.i_valid = v;
    bus.i_ready = r;
    #1;
    exp_ready = (mq.size() < 2);
    exp_valid = (mq.size() > 0);
    exp_last  = exp_valid && (beat == BEATS_PER_LINE - 1);
    chk("o_ready", 64'(bus.o_ready), 64'(exp_ready));
    chk("o_valid", 64'(bus.o_valid), 64'(exp_valid));
    chk("o_last", 64'(bus.o_last), 64'(exp_last));
    if (exp_valid) begin
      head = mq[0];
      p    = head[beat*2*WORD_W +: 2*WORD_W];
      chk("o_word1", 64'(bus.o_word1), 64'(p.w1));
      chk("o_word2", 64'(bus.o_word2), 64'(p.w2));
    end
    if (exp_valid && r) begin
      if (exp_last) begin
        void'(mq.pop_front());
        beat = 0;
        lines_done++;
      end else begin
        beat++;
      end
    end
    if (v && exp_ready) mq.push_back(line);
    @(negedge i_clk);
  endtask

  task automatic offer(input logic [LINE_W-1:0] line, input logic r);
    logic took;
    took = 1'b0;
    for (int k = 0; k < 20 && !took; k++) begin
      took = (mq.size() < 2);
      cyc(line, 1'b1, r);
    end
    chk("offer_accepted", 64'(took), 64'(1));
  endtask

  task automatic idle(input int n, input logic r);
    for (int k = 0; k < n; k++) cyc('0, 1'b0, r);
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    #1;
    chk("rst_o_valid", 64'(bus.o_valid), 64'(0));
    chk("rst_o_last", 64'(bus.o_last), 64'(0));
    chk("rst_o_ready", 64'(bus.o_ready), 64'(0));
    chk("rst_o_word1", 64'(bus.o_word1), 64'(0));
    chk("rst_o_word2", 64'(bus.o_word2), 64'(0));
    mq.delete();
    beat       = 0;
    lines_done = 0;
    @(negedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b0;
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    beat        = 0;
    lines_done  = 0;
    bus.i_line  = '0;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    i_reset     = 1'b0;
    @(negedge i_clk);
    do_reset();

    // single line, drained with ready high
    offer(128'h44444444_33333333_22222222_11111111, 1'b1);
    idle(3, 1'b1);

    // three back-to-back lines
    offer({4{32'hAAAAAAAA}} ^ 128'h3_00000002_00000001_00000000, 1'b1);
    offer({4{32'hBBBBBBBB}}, 1'b1);
    offer({4{32'hCCCCCCCC}}, 1'b1);
    idle(6, 1'b1);

    // downstream stalled with both slots full
    offer(128'h13_12_11_10, 1'b0);
    offer(128'h23_22_21_20, 1'b0);
    idle(5, 1'b0);
    idle(6, 1'b1);

    // new line offered on the last beat of the active line
    offer(128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A, 1'b1);
    cyc('0, 1'b0, 1'b1);
    offer(128'h1D1D1D1D_1C1C1C1C_1B1B1B1B_1A1A1A1A, 1'b1);
    idle(3, 1'b1);

    // reset after the first pair of a line
    offer(128'hFFFF0000_0000FFFF_AAAAAAAA_55555555, 1'b1);
    cyc('0, 1'b0, 1'b1);
    do_reset();
    offer(128'h00000004_00000003_00000002_00000001, 1'b1);
    idle(3, 1'b1);

    // random traffic
    for (int k = 0; k < 400; k++) begin
      cyc({$urandom, $urandom, $urandom, $urandom},
          1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) != 0));
    end
    idle(6, 1'b1);

`ifdef WORD_SPLIT_STATS_EN
    chk("o_line_cnt", 64'(line_cnt), 64'(lines_done[15:0]));
    do_reset();
    chk("o_line_cnt_rst", 64'(line_cnt), 64'(0));
    for (int k = 0; k < 4; k++) offer({4{k[31:0] + 32'h100}}, 1'b1);
    idle(4, 1'b1);
    chk("o_line_cnt_4", 64'(line_cnt), 64'(4));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
